// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video timing defaults, reader states and Wishbone cycle-type codes
package video_pkg;

   localparam int HDISP_DEF = 800;
   localparam int VDISP_DEF = 480;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      READ = 2'd2
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/frame_reader_if.sv
// rtl/frame_reader_if.sv - Wishbone read bus between frame_reader and the SDRAM controller
interface frame_reader_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic [31:0] dat_sm;

   modport master (
      output cyc, stb, we, adr, sel, cti, bte,
      input  ack, err, dat_sm
   );

   modport slave (
      input  cyc, stb, we, adr, sel, cti, bte,
      output ack, err, dat_sm
   );

endinterface

// File: rtl/frame_reader_addr_gen.sv
// rtl/frame_reader_addr_gen.sv - frame word index counter with wrap, clear and end-of-frame/burst flags
module frame_addr_gen #(
   parameter  int NWORDS    = 384000,
   parameter  int BURST_LEN = 8,
   localparam int IW        = $clog2(NWORDS)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [IW-1:0] index,
   output logic          last_word,
   output logic          last_in_burst
);

   assign last_word     = (index == IW'(NWORDS - 1));
   // Bursts are aligned to BURST_LEN words from the frame start, so the
   // position inside a burst is simply the index modulo the burst length.
   assign last_in_burst = ((32'(index) % 32'(BURST_LEN)) == 32'(BURST_LEN - 1));

   // Advance on each terminated word, wrapping at frame end; clear has priority.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         index <= '0;
      end else if (clr) begin
         index <= '0;
      end else if (inc) begin
         index <= last_word ? '0 : index + IW'(1);
      end
   end

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - Wishbone framebuffer reader feeding the pixel FIFO (burst mode: FRAME_READER_BURST_EN)
module frame_reader
   import video_pkg::*;
#(
   parameter int          HDISP     = HDISP_DEF,
   parameter int          VDISP     = VDISP_DEF,
   parameter logic [31:0] BASE_ADR  = 32'h0,
   parameter int          BURST_LEN = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  enable,
   frame_reader_if.master        wshb,
   output logic [31:0]           fifo_wdata,
   output logic                  fifo_write,
   input  logic                  fifo_walmost_full,
   output logic                  frame_done,
   output logic [7:0]            err_cnt
);

   localparam int NWORDS = HDISP * VDISP;
   localparam int IW     = $clog2(NWORDS);

`ifdef FRAME_READER_BURST_EN
   localparam bit BURST_MODE = 1'b1;
`else
   localparam bit BURST_MODE = 1'b0;
`endif

   // Classic mode is a burst of one word, so the FSM needs no mode split.
   localparam int BURST_EFF = BURST_MODE ? BURST_LEN : 1;

   state_t          state;
   state_t          next_state;
   logic            term;
   logic            last_word;
   logic            last_in_burst;
   logic [IW-1:0]   index;

   assign term = (state == READ) && (wshb.ack || wshb.err);

   frame_addr_gen #(
      .NWORDS    (NWORDS),
      .BURST_LEN (BURST_EFF)
   ) u_addr_gen (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .inc           (term),
      .clr           (next_state == IDLE),
      .index         (index),
      .last_word     (last_word),
      .last_in_burst (last_in_burst)
   );

   assign wshb.we  = 1'b0;
   assign wshb.sel = 4'hF;
   assign wshb.bte = 2'b00;
   assign wshb.adr = BASE_ADR + 32'({index, 2'b00});

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: a started read or burst always runs to its final termination.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (enable) next_state = HOLD;
         end
         HOLD: begin
            if (!enable)                 next_state = IDLE;
            else if (!fifo_walmost_full) next_state = READ;
         end
         READ: begin
            if (term && last_in_burst) next_state = enable ? HOLD : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Bus outputs decoded from state.
   always_comb begin
      wshb.cyc = 1'b0;
      wshb.stb = 1'b0;
      wshb.cti = CTI_CLASSIC;
      if (state == READ) begin
         wshb.cyc = 1'b1;
         wshb.stb = 1'b1;
         if (BURST_MODE) wshb.cti = last_in_burst ? CTI_EOB : CTI_INCR;
      end
   end

   // Register each terminated word into the FIFO; errored words become black pixels.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         fifo_write <= 1'b0;
         fifo_wdata <= 32'h0;
         frame_done <= 1'b0;
         err_cnt    <= 8'h0;
      end else begin
         fifo_write <= term;
         frame_done <= term && last_word;
         if (term) fifo_wdata <= wshb.err ? 32'h0 : wshb.dat_sm;
         if (term && wshb.err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - directed self-checking bench for frame_reader
module tb_frame_reader;
   import video_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        enable;
   logic        fifo_walmost_full;
   logic [31:0] fifo_wdata;
   logic        fifo_write;
   logic        frame_done;
   logic [7:0]  err_cnt;

   frame_reader_if wb();

   frame_reader #(
      .HDISP     (4),
      .VDISP     (2),
      .BASE_ADR  (32'h100),
      .BURST_LEN (4)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_rst_n         (sys_rst_n),
      .enable            (enable),
      .wshb              (wb),
      .fifo_wdata        (fifo_wdata),
      .fifo_write        (fifo_write),
      .fifo_walmost_full (fifo_walmost_full),
      .frame_done        (frame_done),
      .err_cnt           (err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] adr_log[$];
   logic [2:0]  cti_log[$];
   logic [31:0] wdata_log[$];
   logic        done_log[$];
   int          wcnt = 0;
   int          lat_bad = 0;
   int          stb_gap = 0;
   int          err_terms = 0;
   bit          err_all = 0;
   bit          err_one_en = 0;
   bit          in_burst = 0;
   logic [31:0] err_adr = 32'h0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave answers each strobe after 2 cycles; monitor checks 1-cycle write latency and burst stb continuity
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (fifo_write !== (wb.ack || wb.err)) lat_bad++;
         if (fifo_write) begin
            wdata_log.push_back(fifo_wdata);
            done_log.push_back(frame_done);
         end
         if (in_burst && !wb.stb) stb_gap++;
      end else begin
         in_burst = 0;
      end
      if (wb.ack || wb.err) begin
         wb.ack = 1'b0;
         wb.err = 1'b0;
         wcnt   = 0;
      end else if (sys_rst_n && wb.cyc && wb.stb) begin
         wcnt++;
         if (wcnt == 2) begin
            wcnt = 0;
            adr_log.push_back(wb.adr);
            cti_log.push_back(wb.cti);
            in_burst = (wb.cti == CTI_INCR);
            wb.dat_sm = {16'hD000, wb.adr[15:0]};
            if (err_all || (err_one_en && wb.adr == err_adr)) begin
               wb.err = 1'b1;
               err_one_en = 0;
               err_terms++;
            end else begin
               wb.ack = 1'b1;
            end
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic wait_acks(int n, int budget, string tag);
      int c = 0;
      while (adr_log.size() < n && c < budget) begin
         @(negedge sys_clk);
         c++;
      end
      check({tag, "_timeout"}, 32'(adr_log.size() >= n), 32'd1);
   endtask

   task automatic wait_strobe(int budget, string tag);
      int c = 0;
      do begin
         @(negedge sys_clk);
         c++;
      end while (!(wb.stb && !wb.ack && !wb.err) && c < budget);
      check({tag, "_timeout"}, 32'(wb.stb), 32'd1);
   endtask

   task automatic wait_idle(int budget, string tag);
      int c = 0;
      while (wb.cyc && c < budget) begin
         @(negedge sys_clk);
         c++;
      end
      check({tag, "_timeout"}, 32'(wb.cyc), 32'd0);
   endtask

   task automatic clear_logs();
      adr_log.delete();
      cti_log.delete();
      wdata_log.delete();
      done_log.delete();
   endtask

   initial begin
      int          k;
      int          stb_hi;
      int          n_eob;
      logic [31:0] exp_adr;

      sys_rst_n         = 1'b0;
      enable            = 1'b0;
      fifo_walmost_full = 1'b0;
      wb.ack            = 1'b0;
      wb.err            = 1'b0;
      wb.dat_sm         = 32'h0;
      repeat (3) @(negedge sys_clk);

      check("rst_cyc", 32'(wb.cyc), 32'd0);
      check("rst_stb", 32'(wb.stb), 32'd0);
      check("rst_fifo_write", 32'(fifo_write), 32'd0);
      check("rst_fifo_wdata", fifo_wdata, 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_cti", 32'(wb.cti), 32'd0);
      check("rst_adr", wb.adr, 32'h100);
      check("rst_we", 32'(wb.we), 32'd0);
      check("rst_sel", 32'(wb.sel), 32'hF);
      check("rst_bte", 32'(wb.bte), 32'd0);

      // Full frame plus wrap
      sys_rst_n = 1'b1;
      enable    = 1'b1;
      wait_acks(9, 300, "frame");
      repeat (3) @(negedge sys_clk);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("frame_adr%0d", i), adr_log[i], 32'h100 + 32'(4 * (i % 8)));
      end
      for (int i = 0; i < 8; i++) begin
         check($sformatf("frame_data%0d", i), wdata_log[i], 32'hD000_0100 + 32'(4 * i));
         check($sformatf("frame_done%0d", i), 32'(done_log[i]), 32'(i == 7));
      end
      check("frame_done8", 32'(done_log[8]), 32'd0);

      // Enable dropped while strobing
      wait_strobe(50, "drop_stb");
      enable = 1'b0;
      wait_idle(50, "drop_idle");
      repeat (3) @(negedge sys_clk);
      check("drop_all_written", 32'(wdata_log.size()), 32'(adr_log.size()));
      check("drop_last_word", wdata_log[$], {16'hD000, adr_log[$][15:0]});
      repeat (5) @(negedge sys_clk);
      check("drop_stays_idle", 32'(wb.stb), 32'd0);
      clear_logs();
      enable = 1'b1;
      wait_acks(1, 50, "reenable");
      check("reenable_adr", adr_log[0], 32'h100);

      // FIFO almost full holds off new reads
      wait_strobe(50, "af_stb");
      fifo_walmost_full = 1'b1;
      wait_idle(50, "af_idle");
      exp_adr = 32'h100 + ((adr_log[$] - 32'h100 + 32'd4) % 32'd32);
      stb_hi = 0;
      repeat (20) begin
         @(negedge sys_clk);
         if (wb.stb) stb_hi++;
      end
      check("af_no_stb", 32'(stb_hi), 32'd0);
      fifo_walmost_full = 1'b0;
      k = 0;
      while (!wb.stb && k < 5) begin
         @(negedge sys_clk);
         k++;
      end
      check("af_release_latency", 32'(wb.stb && k <= 2), 32'd1);
      check("af_release_adr", wb.adr, exp_adr);

      // Error on third word, then saturation
      enable = 1'b0;
      wait_idle(50, "err_idle");
      repeat (3) @(negedge sys_clk);
      clear_logs();
      err_adr    = 32'h108;
      err_one_en = 1;
      enable     = 1'b1;
      wait_acks(4, 100, "err");
      repeat (3) @(negedge sys_clk);
      check("err_word1", wdata_log[1], 32'hD000_0104);
      check("err_word2_zero", wdata_log[2], 32'h0);
      check("err_word3", wdata_log[3], 32'hD000_010C);
      check("err_adr3", adr_log[3], 32'h10C);
      check("err_cnt1", 32'(err_cnt), 32'd1);
      err_all = 1;
      k = 0;
      while (err_terms < 301 && k < 3000) begin
         @(negedge sys_clk);
         k++;
      end
      err_all = 0;
      check("err_many_timeout", 32'(err_terms >= 301), 32'd1);
      repeat (3) @(negedge sys_clk);
      check("err_cnt_sat", 32'(err_cnt), 32'd255);

      // Asynchronous reset in the middle of a read
      wait_strobe(50, "rst_mid_stb");
      #2 sys_rst_n = 1'b0;
      #1;
      check("rst_mid_cyc", 32'(wb.cyc), 32'd0);
      check("rst_mid_stb", 32'(wb.stb), 32'd0);
      check("rst_mid_fifo_write", 32'(fifo_write), 32'd0);
      repeat (3) @(negedge sys_clk);
      clear_logs();
      sys_rst_n = 1'b1;
      wait_acks(1, 50, "rst_rel");
      check("rst_rel_adr", adr_log[0], 32'h100);

      // Cycle-type sequence over a fresh frame
      enable = 1'b0;
      wait_idle(50, "cti_idle");
      repeat (3) @(negedge sys_clk);
      clear_logs();
      stb_gap = 0;
      enable  = 1'b1;
      wait_acks(8, 300, "cti");
      repeat (3) @(negedge sys_clk);
      n_eob = 0;
      for (int i = 0; i < 8; i++) begin
         if (cti_log[i] == CTI_EOB) n_eob++;
`ifdef FRAME_READER_BURST_EN
         check($sformatf("cti%0d", i), 32'(cti_log[i]), 32'((i % 4 == 3) ? CTI_EOB : CTI_INCR));
`else
         check($sformatf("cti%0d", i), 32'(cti_log[i]), 32'(CTI_CLASSIC));
`endif
      end
`ifdef FRAME_READER_BURST_EN
      check("bursts_per_frame", 32'(n_eob), 32'd2);
`else
      check("no_eob_classic", 32'(n_eob), 32'd0);
`endif
      check("cti_frame_done", 32'(done_log[7]), 32'd1);
      check("stb_gap", 32'(stb_gap), 32'd0);
      check("write_latency", 32'(lat_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Wishbone master in the sys_clk domain.
- Reads the framebuffer from SDRAM sequentially and pushes each 32-bit pixel word into the write side of the pixel FIFO.
- The vga stage drains that FIFO.
- Sits directly upstream of vga, on the wshb_if_sdram bus now tied off in the top level.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BASE_ADR, 32'h0, byte address of pixel (0,0); must be 4-byte aligned
- BURST_LEN, 8, words per burst (used only with the optional feature)

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = fetch frames continuously
- wshb_cyc  out  1  Wishbone cycle
- wshb_stb  out  1  Wishbone strobe
- wshb_we  out  1  constant 0
- wshb_adr  out  32  byte address
- wshb_sel  out  4  constant 4'hF
- wshb_cti  out  3  cycle type
- wshb_bte  out  2  constant 2'b00
- wshb_ack  in  1  slave acknowledge
- wshb_err  in  1  slave error
- wshb_dat_sm  in  32  read data
- fifo_wdata  out  32  pixel word to FIFO
- fifo_write  out  1  FIFO write strobe
- fifo_walmost_full  in  1  FIFO has fewer than BURST_LEN+2 free slots
- frame_done  out  1  one-cycle pulse after the last word of a frame is written
- err_cnt  out  8  saturating count of wshb_err terminations

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - state=IDLE, address=BASE_ADR.
  - cyc=stb=0, fifo_write=0, fifo_wdata=0, frame_done=0, err_cnt=0, cti=3'b000.
- Frame size: NWORDS = HDISP*VDISP. The word index counter is $clog2(NWORDS) bits wide. wshb_adr = BASE_ADR + 4*index.
- State machine:
  - IDLE: cyc=stb=0. Go to HOLD when enable=1.
  - HOLD: cyc=stb=0. Go to READ when fifo_walmost_full=0. Go to IDLE if enable=0.
  - READ: cyc=stb=1 and adr held stable until ack or err.
    - On termination, the index increments.
    - Next state is HOLD if enable=1, else IDLE.
    - A transaction in flight is always completed; stb is never dropped before ack or err.
- FIFO write: registered. fifo_write=1 and fifo_wdata=captured word on the cycle after ack/err, so latency is 1 cycle.
- err: terminates the transfer like ack, but writes 32'h0 so pixel alignment is kept. err_cnt increments and saturates at 255.
- ack and err together: err takes precedence.
- Wrap: when the word at index NWORDS-1 terminates:
  - index returns to 0;
  - frame_done pulses together with that word's fifo_write.
- Entry into IDLE (enable low) resets the index to 0, so the next enable always starts at pixel (0,0). err_cnt is kept.
- Reset asserted mid-transaction: cyc and stb drop immediately. The slave must tolerate this.
- fifo_walmost_full is sampled only in HOLD. The threshold guarantees no overflow, including the 1-cycle write latency.

Optional Feature:
- Macro: FRAME_READER_BURST_EN.
- Defined:
  - READ issues an incrementing burst of BURST_LEN words, with cti=3'b010 on all words but the last, which uses cti=3'b111.
  - stb stays high across acks; adr advances on each ack.
  - enable low mid-burst: the burst still completes.
  - A burst never crosses the frame end; NWORDS must be a multiple of BURST_LEN.
- Undefined: single classic reads, cti=3'b000 always. BURST_LEN is ignored.

Decomposition:
- Package video_pkg holds:
  - HDISP/VDISP defaults;
  - state enum {IDLE, HOLD, READ};
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
- One sub-module, frame_addr_gen: word index counter with wrap, index clear, and last-word / last-in-burst flags.

Test Plan:
- HDISP=4, VDISP=2, BASE_ADR=32'h100, slave acks after 2 cycles, enable=1:
  - reads hit 0x100..0x11C in order, then wrap to 0x100;
  - frame_done pulses with the 8th fifo_write;
  - data is written to the FIFO 1 cycle after each ack.
- Hold fifo_walmost_full=1 for 20 cycles:
  - no stb is asserted;
  - on release, stb rises within 2 cycles at the next address.
- enable drops while stb=1:
  - the transaction completes and its word is written;
  - the block goes IDLE;
  - on re-enable the first adr is 0x100.
- Slave returns err on the 3rd word:
  - fifo_wdata=0 for that word, err_cnt=1, addresses continue at 0x10C;
  - 300 errors leave err_cnt=255.
- Assert sys_rst_n=0 mid-READ, asynchronously between edges:
  - cyc, stb and fifo_write go low immediately;
  - after release, the first read is at 0x100.
- FRAME_READER_BURST_EN defined, BURST_LEN=4:
  - cti sequence per burst is 010,010,010,111;
  - stb is continuous across acks within a burst;
  - 2 bursts per frame.
